// File: rtl/fetch_cycle_if.sv
// Instruction-memory request/acknowledge port between the fetch stage and memory.
// The address must stay stable while a request is pending; ack may arrive in the same cycle.
interface fetch_cycle_if #(
  parameter int PC_W    = 18,
  parameter int INSTR_W = 33
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_cycle.sv
// Instruction-fetch stage with IF/ID register, branch redirect (including redirects
// with a wrong-path fetch outstanding) and a one-entry hold buffer for stalls.
module fetch_cycle #(
  parameter int PC_W     = 18,
  parameter int INSTR_W  = 33,
  parameter int RESET_PC = 0,
  parameter int PC_INC   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               StallF,
  input  logic               FlushD,
  input  logic               PCSrcE,
  input  logic [PC_W-1:0]    PCTargetE,
  fetch_cycle_if.master      imem,
  output logic [INSTR_W-1:0] InstrD,
  output logic [PC_W-1:0]    PCD,
  output logic [PC_W-1:0]    PCPlus4D,
  output logic               ValidD
);

  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] INC    = PC_W'(PC_INC);

  typedef enum logic [1:0] {BOOT, FETCH, KILL, HOLD} state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pcf_q, pcf_d;
  logic [PC_W-1:0]    redir_q, redir_d;
  logic [INSTR_W-1:0] buf_instr_q, buf_instr_d;
  logic [PC_W-1:0]    buf_pc_q, buf_pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pcd_q, pcd_d;
  logic [PC_W-1:0]    pcp4_q, pcp4_d;
  logic               valid_q, valid_d;

  logic               deliver;
  logic [INSTR_W-1:0] dlv_instr;
  logic [PC_W-1:0]    dlv_pc;

  assign imem.imem_req  = (state_q == FETCH) || (state_q == KILL);
  assign imem.imem_addr = pcf_q;

  always_comb begin
    state_d     = state_q;
    pcf_d       = pcf_q;
    redir_d     = redir_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    deliver     = 1'b0;
    dlv_instr   = '0;
    dlv_pc      = '0;

    unique case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (imem.imem_ack) begin
          if (PCSrcE) begin
            pcf_d = PCTargetE;
          end else begin
            pcf_d = pcf_q + INC;
            if (!StallF) begin
              deliver   = 1'b1;
              dlv_instr = imem.imem_rdata;
              dlv_pc    = pcf_q;
            end else begin
              buf_instr_d = imem.imem_rdata;
              buf_pc_d    = pcf_q;
              state_d     = HOLD;
            end
          end
        end else if (PCSrcE) begin
          // Request cannot be withdrawn: park the target until the wrong-path ack.
          redir_d = PCTargetE;
          state_d = KILL;
        end
      end
      KILL: begin
        if (PCSrcE) redir_d = PCTargetE;
        if (imem.imem_ack) begin
          pcf_d   = PCSrcE ? PCTargetE : redir_q;
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (PCSrcE) begin
          pcf_d       = PCTargetE;
          buf_instr_d = '0;
          buf_pc_d    = '0;
          state_d     = FETCH;
        end else if (!StallF) begin
          deliver   = 1'b1;
          dlv_instr = buf_instr_q;
          dlv_pc    = buf_pc_q;
          state_d   = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    instr_d = '0;
    pcd_d   = '0;
    pcp4_d  = '0;
    valid_d = 1'b0;
    if (FlushD || PCSrcE) begin
      valid_d = 1'b0;
    end else if (StallF) begin
      instr_d = instr_q;
      pcd_d   = pcd_q;
      pcp4_d  = pcp4_q;
      valid_d = valid_q;
    end else if (deliver) begin
      instr_d = dlv_instr;
      pcd_d   = dlv_pc;
      pcp4_d  = dlv_pc + INC;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= BOOT;
      pcf_q       <= RST_PC;
      redir_q     <= '0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
      instr_q     <= '0;
      pcd_q       <= '0;
      pcp4_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcf_q       <= pcf_d;
      redir_q     <= redir_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      instr_q     <= instr_d;
      pcd_q       <= pcd_d;
      pcp4_q      <= pcp4_d;
      valid_q     <= valid_d;
    end
  end

  assign InstrD   = instr_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pcp4_q;
  assign ValidD   = valid_q;

endmodule

// File: tb/tb_fetch_cycle.sv
// Directed bench for fetch_cycle: memory returns instr = addr, ack either
// mirrors the request (zero-wait) or is driven cycle by cycle.
module tb_fetch_cycle;

  localparam int PC_W    = 18;
  localparam int INSTR_W = 33;

  logic            clk = 1'b0;
  logic            rst;
  logic            StallF, FlushD, PCSrcE;
  logic [PC_W-1:0] PCTargetE;
  logic [INSTR_W-1:0] InstrD;
  logic [PC_W-1:0] PCD, PCPlus4D;
  logic            ValidD;
  logic            auto_ack, man_ack;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  fetch_cycle_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) imem_bus ();

  assign imem_bus.imem_ack   = auto_ack ? imem_bus.imem_req : man_ack;
  assign imem_bus.imem_rdata = INSTR_W'(imem_bus.imem_addr);

  fetch_cycle #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(0), .PC_INC(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .StallF   (StallF),
    .FlushD   (FlushD),
    .PCSrcE   (PCSrcE),
    .PCTargetE(PCTargetE),
    .imem     (imem_bus.master),
    .InstrD   (InstrD),
    .PCD      (PCD),
    .PCPlus4D (PCPlus4D),
    .ValidD   (ValidD)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [PC_W-1:0] pc, input logic v);
    check({tag, "_valid"}, 64'(ValidD), 64'(v));
    check({tag, "_pcd"},   64'(PCD), v ? 64'(pc) : 64'd0);
    check({tag, "_instr"}, 64'(InstrD), v ? 64'(pc) : 64'd0);
    check({tag, "_pcp4"},  64'(PCPlus4D), v ? 64'(PC_W'(pc + 18'd4)) : 64'd0);
  endtask

  initial begin
    rst = 1'b0; StallF = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
    auto_ack = 1'b1; man_ack = 1'b0;
    #3;
    check("rst_req", 64'(imem_bus.imem_req), 64'd0);
    check("rst_addr", 64'(imem_bus.imem_addr), 64'd0);
    chk_ifid("rst", '0, 1'b0);
    #5 rst = 1'b1;

    tick();
    check("boot_req", 64'(imem_bus.imem_req), 64'd1);
    check("boot_addr", 64'(imem_bus.imem_addr), 64'd0);
    check("boot_valid", 64'(ValidD), 64'd0);

    // zero-wait streaming
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_ifid("stream", PC_W'(4 * i), 1'b1);
      check("stream_addr", 64'(imem_bus.imem_addr), 64'(4 * i + 4));
    end

    // three-cycle latency at PC 8
    auto_ack = 1'b0; man_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("lat_addr", 64'(imem_bus.imem_addr), 64'h8);
      chk_ifid("lat_bubble", '0, 1'b0);
    end
    man_ack = 1'b1;
    tick();
    chk_ifid("lat_done", 18'h8, 1'b1);
    check("lat_next", 64'(imem_bus.imem_addr), 64'hc);

    // stall with ack on stall cycle 1
    StallF = 1'b1;
    tick();
    man_ack = 1'b0;
    chk_ifid("stall1", 18'h8, 1'b1);
    check("stall1_req", 64'(imem_bus.imem_req), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_req", 64'(imem_bus.imem_req), 64'd0);
      check("stall_pcd", 64'(PCD), 64'h8);
    end
    StallF = 1'b0;
    tick();
    chk_ifid("unstall", 18'hc, 1'b1);
    check("unstall_addr", 64'(imem_bus.imem_addr), 64'h10);
    tick();
    check("once_valid", 64'(ValidD), 64'd0);
    check("once_addr", 64'(imem_bus.imem_addr), 64'h10);

    // redirect while request to 0x20 pending
    auto_ack = 1'b1;
    repeat (4) tick();
    check("pre_kill_addr", 64'(imem_bus.imem_addr), 64'h20);
    auto_ack = 1'b0; man_ack = 1'b0; PCSrcE = 1'b1; PCTargetE = 18'h100;
    tick();
    PCSrcE = 1'b0;
    check("kill_req", 64'(imem_bus.imem_req), 64'd1);
    check("kill_addr", 64'(imem_bus.imem_addr), 64'h20);
    chk_ifid("kill_bubble", '0, 1'b0);
    tick();
    check("kill_hold_addr", 64'(imem_bus.imem_addr), 64'h20);
    chk_ifid("kill_bubble2", '0, 1'b0);
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    chk_ifid("kill_discard", '0, 1'b0);
    check("redir_addr", 64'(imem_bus.imem_addr), 64'h100);

    // same-cycle ack and redirect
    man_ack = 1'b1; PCSrcE = 1'b1; PCTargetE = 18'h200;
    tick();
    man_ack = 1'b0; PCSrcE = 1'b0;
    chk_ifid("ackbr", '0, 1'b0);
    check("ackbr_addr", 64'(imem_bus.imem_addr), 64'h200);
    check("ackbr_req", 64'(imem_bus.imem_req), 64'd1);

    // flush wins over stall
    auto_ack = 1'b1;
    tick();
    chk_ifid("pre_flush", 18'h200, 1'b1);
    FlushD = 1'b1; StallF = 1'b1;
    tick();
    FlushD = 1'b0; StallF = 1'b0;
    chk_ifid("flush_stall", '0, 1'b0);
    tick();
    chk_ifid("post_flush", 18'h204, 1'b1);

    // PC wrap
    PCSrcE = 1'b1; PCTargetE = 18'h3fffc;
    tick();
    PCSrcE = 1'b0;
    check("wrap_addr", 64'(imem_bus.imem_addr), 64'h3fffc);
    tick();
    check("wrap_pcd", 64'(PCD), 64'h3fffc);
    check("wrap_instr", 64'(InstrD), 64'h3fffc);
    check("wrap_pcp4", 64'(PCPlus4D), 64'd0);
    check("wrap_next", 64'(imem_bus.imem_addr), 64'd0);
    tick();
    chk_ifid("post_wrap", 18'h0, 1'b1);

    // asynchronous reset mid-request
    auto_ack = 1'b0; man_ack = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst_req", 64'(imem_bus.imem_req), 64'd0);
    check("arst_addr", 64'(imem_bus.imem_addr), 64'd0);
    chk_ifid("arst", '0, 1'b0);
    #3 rst = 1'b1;
    tick();
    check("rerun_req", 64'(imem_bus.imem_req), 64'd1);
    check("rerun_addr", 64'(imem_bus.imem_addr), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
